data_ram_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters. Port 0 is the pipeline load/store port, issued from EXE with the response consumed in MEM/WB. Port 1 is the secondary port (debug/DMA/init loader).
- Arbitrates per cycle and drives the RAM.
- Captures the 1-cycle-latency read data into a per-port response buffer, so read data survives downstream stalls (WB_allow_in low).

---
 rtl/data_ram_arbiter_pkg.sv | 23 ++
 rtl/data_ram_rsp_buf.sv | 34 +++
 rtl/data_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter slice.
//   - bus-width defaults for the requester / RAM ports
//   - port encoding (DATA_RAM_PORT_P0 / DATA_RAM_PORT_P1)
//   - request bus width helper and the default starvation limit
package data_ram_arbiter_pkg;

    localparam int DRAM_ADDR_W     = 32;
    localparam int DRAM_DATA_W     = 32;
    localparam int DRAM_STARVE_MAX = 4;

    typedef enum logic {
        DATA_RAM_PORT_P0 = 1'b0,
        DATA_RAM_PORT_P1 = 1'b1
    } data_ram_port_e;

    // Width of a packed {we, addr, wdata} request bus.
    function automatic int req_bus_w(input int addr_w, input int data_w);
        return data_w / 8 + addr_w + data_w;
    endfunction

    localparam int DRAM_REQ_BUS_W = req_bus_w(DRAM_ADDR_W, DRAM_DATA_W);

endpackage

// File: rtl/data_ram_rsp_buf.sv
// Single-entry valid/ready holding register for one port's read response.
// Ports:
//   clk, reset      clock, async active-high reset
//   fill            load fill_data this cycle (read data returning from RAM)
//   fill_data       RAM read data
//   rsp_ready       consumer takes the held data this cycle
//   rsp_valid       held data present
//   rsp_rdata       held data; stable until taken
module data_ram_rsp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);

    // A fill in the same cycle as a drain wins: the new data is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (fill) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= fill_data;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Port 0 is the pipeline load/store port and has priority; port 1
// (debug/DMA/loader) is forced through after STARVE_MAX consecutive
// denied cycles. The request is steered to the RAM combinationally; read
// data (1-cycle RAM latency) is captured into a per-port response buffer.
// Ports:
//   clk, reset                         clock, async active-high reset
//   pN_req_valid/ready/we/addr/wdata   request channel, we==0 means read
//   pN_rsp_valid/ready/rdata           read response channel
//   ram_en/we/addr/wdata, ram_rdata    RAM macro interface
// Optional: define DATA_RAM_ARB_STAT_EN to add wrapping 32-bit counters
//   stat_p0_grants, stat_p1_grants, stat_conflicts (both ports eligible).
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DRAM_ADDR_W,
    parameter int DATA_W     = DRAM_DATA_W,
    parameter int STARVE_MAX = DRAM_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic [DATA_W/8-1:0] p0_req_we,
    input  logic [ADDR_W-1:0]   p0_req_addr,
    input  logic [DATA_W-1:0]   p0_req_wdata,
    output logic                p0_rsp_valid,
    input  logic                p0_rsp_ready,
    output logic [DATA_W-1:0]   p0_rsp_rdata,
    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic [DATA_W/8-1:0] p1_req_we,
    input  logic [ADDR_W-1:0]   p1_req_addr,
    input  logic [DATA_W-1:0]   p1_req_wdata,
    output logic                p1_rsp_valid,
    input  logic                p1_rsp_ready,
    output logic [DATA_W-1:0]   p1_rsp_rdata,
`ifdef DATA_RAM_ARB_STAT_EN
    output logic [31:0]         stat_p0_grants,
    output logic [31:0]         stat_p1_grants,
    output logic [31:0]         stat_conflicts,
`endif
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [1:0]             req_valid, rsp_ready, rsp_valid;
    logic [1:0]             buf_free, eligible, grant, fill;
    logic [1:0][BE_W-1:0]   req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata, rsp_rdata;

    logic [SC_W-1:0]        starve_cnt;
    logic                   starve_hit;
    logic                   inflight;
    data_ram_port_e         inflight_port, gnt_port;
    logic                   gnt_is_read;

    assign req_valid = {p1_req_valid, p0_req_valid};
    assign req_we    = {p1_req_we, p0_req_we};
    assign req_addr  = {p1_req_addr, p0_req_addr};
    assign req_wdata = {p1_req_wdata, p0_req_wdata};
    assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

    for (genvar g = 0; g < 2; g++) begin : g_port
        // The buffer can take a new read only if it will be empty when the
        // data returns and no read for this port is already on its way.
        assign fill[g]     = inflight && (inflight_port == data_ram_port_e'(g));
        assign buf_free[g] = (!rsp_valid[g] || rsp_ready[g]) && !fill[g];
        assign eligible[g] = !reset && req_valid[g] && ((|req_we[g]) || buf_free[g]);

        data_ram_rsp_buf #(.DATA_W(DATA_W)) u_rsp_buf (
            .clk       (clk),
            .reset     (reset),
            .fill      (fill[g]),
            .fill_data (ram_rdata),
            .rsp_ready (rsp_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g])
        );
    end

    assign starve_hit = (starve_cnt == SC_W'(STARVE_MAX));
    assign grant[1]   = eligible[1] && (!eligible[0] || starve_hit);
    assign grant[0]   = eligible[0] && !grant[1];
    assign gnt_port   = grant[1] ? DATA_RAM_PORT_P1 : DATA_RAM_PORT_P0;

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_rsp_rdata = rsp_rdata[0];
    assign p1_rsp_rdata = rsp_rdata[1];

    assign ram_en      = |grant;
    assign ram_we      = ram_en ? req_we[gnt_port] : '0;
    assign ram_addr    = req_addr[gnt_port];
    assign ram_wdata   = req_wdata[gnt_port];
    assign gnt_is_read = ram_en && !(|req_we[gnt_port]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight      <= 1'b0;
            inflight_port <= DATA_RAM_PORT_P0;
            starve_cnt    <= '0;
        end else begin
            inflight      <= gnt_is_read;
            inflight_port <= gnt_port;
            if (grant[1] || !p1_req_valid)
                starve_cnt <= '0;
            else if (eligible[1] && grant[0] && !starve_hit)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

`ifdef DATA_RAM_ARB_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_p0_grants <= '0;
            stat_p1_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant[0])     stat_p0_grants <= stat_p0_grants + 32'd1;
            if (grant[1])     stat_p1_grants <= stat_p1_grants + 32'd1;
            if (&eligible)    stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;
    localparam int AW = 32, DW = 32, BW = 4, SMAX = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          p0_req_valid = 0, p0_req_ready, p0_rsp_valid, p0_rsp_ready = 0;
    logic [BW-1:0] p0_req_we = 0;
    logic [AW-1:0] p0_req_addr = 0;
    logic [DW-1:0] p0_req_wdata = 0, p0_rsp_rdata;
    logic          p1_req_valid = 0, p1_req_ready, p1_rsp_valid, p1_rsp_ready = 0;
    logic [BW-1:0] p1_req_we = 0;
    logic [AW-1:0] p1_req_addr = 0;
    logic [DW-1:0] p1_req_wdata = 0, p1_rsp_rdata;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef DATA_RAM_ARB_STAT_EN
    logic [31:0]   stat_p0_grants, stat_p1_grants, stat_conflicts;
`endif

    int total = 0, bad = 0;

    data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
`ifdef DATA_RAM_ARB_STAT_EN
        .stat_p0_grants(stat_p0_grants), .stat_p1_grants(stat_p1_grants),
        .stat_conflicts(stat_conflicts),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous, byte-writable, 1-cycle read latency.
    logic [31:0] ram [0:255];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_en) begin
            for (int b = 0; b < BW; b++)
                if (ram_we[b]) ram[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= ram[ram_addr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic set_p1(input logic v, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    // Step to the next negedge and settle, so checks sit away from posedge.
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0);
        p0_rsp_ready = 0; p1_rsp_ready = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    typedef struct {
        logic v0; logic [3:0] we0; logic v1; logic [3:0] we1;
        logic r0; logic r1; logic en; logic [3:0] rwe; logic [31:0] raddr;
    } vec_t;
    vec_t tbl [7];

    // Reference model state for the random phase.
    logic [31:0] mm [0:255];
    bit          mv [2];
    logic [31:0] md [2];
    bit          mp [2];
    logic [31:0] mpd [2];
    int          ms;

    initial begin
        tbl[0] = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 32'h0};
        tbl[1] = '{1, 4'h0, 0, 4'h0, 1, 0, 1, 4'h0, 32'h100};
        tbl[2] = '{0, 4'h0, 1, 4'h0, 0, 1, 1, 4'h0, 32'h200};
        tbl[3] = '{1, 4'h0, 1, 4'h0, 1, 0, 1, 4'h0, 32'h100};
        tbl[4] = '{1, 4'hF, 1, 4'h0, 1, 0, 1, 4'hF, 32'h100};
        tbl[5] = '{0, 4'h0, 1, 4'h3, 0, 1, 1, 4'h3, 32'h200};
        tbl[6] = '{1, 4'h0, 1, 4'hC, 1, 0, 1, 4'h0, 32'h100};

        // ---- reset state, including a request held during reset
        #1;
        set_p0(1, 0, 32'h10, 0);
        #1;
        chk("rst_p0_ready", p0_req_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_p0_rsp_valid", p0_rsp_valid, 0);
        chk("rst_p1_rsp_valid", p1_rsp_valid, 0);
        chk("rst_p0_rdata", p0_rsp_rdata, 0);
        set_p0(0, 0, 0, 0);
        @(negedge clk); reset = 0;

        // ---- table: pure grant/steering from an idle state
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_p0(tbl[i].v0, tbl[i].we0, 32'h100, 32'h0);
            set_p1(tbl[i].v1, tbl[i].we1, 32'h200, 32'h0);
            #1;
            chk($sformatf("tbl%0d_p0_ready", i), p0_req_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_p1_ready", i), p1_req_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_ram_en", i), ram_en, tbl[i].en);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].rwe);
            if (tbl[i].en) chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].raddr);
            #1;
            set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0);
        end

        // ---- reset asserted while a p0 read is in flight
        reset_pulse();
        @(negedge clk);
        set_p0(1, 0, 32'h10, 0); #1;
        chk("mid_rd_granted", p0_req_ready, 1);
        @(posedge clk); #1;
        reset = 1; #1;
        chk("mid_rd_ram_en_in_reset", ram_en, 0);
        chk("mid_rd_ready_in_reset", p0_req_ready, 0);
        @(negedge clk); set_p0(0, 0, 0, 0); reset = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_rd_rsp_valid", p0_rsp_valid, 0);
        end

        // ---- write then read back, 2-edge response latency
        @(negedge clk); set_p0(1, 4'hF, 32'h10, 32'hDEADBEEF); #1;
        chk("wr_accept", p0_req_ready, 1);
        @(negedge clk); set_p0(1, 4'h0, 32'h10, 0); #1;
        chk("rd_accept", p0_req_ready, 1);
        @(negedge clk); set_p0(0, 0, 0, 0); #1;
        chk("rd_lat_edge1", p0_rsp_valid, 0);
        step();
        chk("rd_lat_edge2", p0_rsp_valid, 1);
        chk("rd_data", p0_rsp_rdata, 32'hDEADBEEF);
        p0_rsp_ready = 1;
        step(); p0_rsp_ready = 0;
        chk("rd_drained", p0_rsp_valid, 0);

        // ---- partial byte write merge
        @(negedge clk); set_p0(1, 4'hF, 32'h20, 32'h11223344);
        @(negedge clk); set_p0(1, 4'b0010, 32'h20, 32'h0000AB00);
        @(negedge clk); set_p0(1, 4'h0, 32'h20, 0); #1;
        chk("bw_rd_accept", p0_req_ready, 1);
        @(negedge clk); set_p0(0, 0, 0, 0);
        step();
        chk("bw_valid", p0_rsp_valid, 1);
        chk("bw_data", p0_rsp_rdata, 32'h1122AB44);
        p0_rsp_ready = 1;
        step(); p0_rsp_ready = 0;

        // ---- stalled consumer: data stable, next read blocked until drain
        @(negedge clk); set_p0(1, 4'h0, 32'h10, 0); #1;
        chk("st_first_accept", p0_req_ready, 1);
        @(negedge clk); set_p0(1, 4'h0, 32'h20, 0); #1;
        chk("st_inflight_block", p0_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("st_hold_valid", p0_rsp_valid, 1);
            chk("st_hold_data", p0_rsp_rdata, 32'hDEADBEEF);
            chk("st_hold_block", p0_req_ready, 0);
        end
        @(negedge clk); p0_rsp_ready = 1; #1;
        chk("st_drain_accept", p0_req_ready, 1);
        @(negedge clk); set_p0(0, 0, 0, 0); #1;
        chk("st_after_drain", p0_rsp_valid, 0);
        step();
        chk("st_second_valid", p0_rsp_valid, 1);
        chk("st_second_data", p0_rsp_rdata, 32'h1122AB44);
        step(); p0_rsp_ready = 0;

        // ---- starvation: both always eligible, p1 forced every 5th cycle
        @(negedge clk);
        set_p0(1, 4'hF, 32'h40, 32'h1);
        set_p1(1, 4'hF, 32'h44, 32'h2);
        #1;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("starve_p1_c%0d", k), p1_req_ready, (k % 5) == 4);
            chk($sformatf("starve_p0_c%0d", k), p0_req_ready, (k % 5) != 4);
            step();
        end
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0);

        // ---- p1 drains and issues the next read in the same cycle
        @(negedge clk); set_p1(1, 4'hF, 32'h80, 32'hAAAA0001);
        @(negedge clk); set_p1(1, 4'hF, 32'h84, 32'hBBBB0002);
        @(negedge clk); p1_rsp_ready = 1; set_p1(1, 4'h0, 32'h80, 0); #1;
        chk("p1_rdA_accept", p1_req_ready, 1);
        @(negedge clk); set_p1(1, 4'h0, 32'h84, 0); #1;
        chk("p1_inflight_block", p1_req_ready, 0);
        step();
        chk("p1_A_valid", p1_rsp_valid, 1);
        chk("p1_A_data", p1_rsp_rdata, 32'hAAAA0001);
        chk("p1_drain_and_accept", p1_req_ready, 1);
        @(negedge clk); set_p1(0, 0, 0, 0); #1;
        chk("p1_gap", p1_rsp_valid, 0);
        step();
        chk("p1_B_valid", p1_rsp_valid, 1);
        chk("p1_B_data", p1_rsp_rdata, 32'hBBBB0002);
        step(); p1_rsp_ready = 0;

        // ---- randomized traffic vs. reference model
        reset_pulse();
        for (int i = 0; i < 256; i++) mm[i] = '0;
        for (int i = 0; i < 2; i++) begin mv[i] = 0; md[i] = 0; mp[i] = 0; mpd[i] = 0; end
        ms = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          v [2];
            logic [3:0]  we [2];
            logic [31:0] a [2];
            logic [31:0] d [2];
            bit          rr [2];
            bit          fr [2];
            bit          el [2];
            bit          g [2];
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                v[i]  = $urandom_range(0, 99) < 75;
                we[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                a[i]  = 32'($urandom_range(0, 15)) << 2;
                d[i]  = $urandom;
                rr[i] = $urandom_range(0, 99) < 60;
            end
            set_p0(v[0], we[0], a[0], d[0]); p0_rsp_ready = rr[0];
            set_p1(v[1], we[1], a[1], d[1]); p1_rsp_ready = rr[1];
            #1;
            for (int i = 0; i < 2; i++) begin
                fr[i] = (!mv[i] || rr[i]) && !mp[i];
                el[i] = v[i] && (we[i] != 0 || fr[i]);
            end
            g[1] = el[1] && (!el[0] || ms == SMAX);
            g[0] = el[0] && !g[1];
            chk("rnd_p0_ready", p0_req_ready, g[0]);
            chk("rnd_p1_ready", p1_req_ready, g[1]);
            chk("rnd_p0_rsp_valid", p0_rsp_valid, mv[0]);
            chk("rnd_p1_rsp_valid", p1_rsp_valid, mv[1]);
            if (mv[0]) chk("rnd_p0_rdata", p0_rsp_rdata, md[0]);
            if (mv[1]) chk("rnd_p1_rdata", p1_rsp_rdata, md[1]);
            // advance the model across the coming edge
            for (int i = 0; i < 2; i++) begin
                if (mp[i]) begin mv[i] = 1; md[i] = mpd[i]; end
                else if (mv[i] && rr[i]) mv[i] = 0;
                mp[i] = g[i] && we[i] == 0;
                if (mp[i]) mpd[i] = mm[a[i][9:2]];
            end
            for (int i = 0; i < 2; i++)
                if (g[i] && we[i] != 0)
                    for (int b = 0; b < 4; b++)
                        if (we[i][b]) mm[a[i][9:2]][b*8 +: 8] = d[i][b*8 +: 8];
            if (g[1] || !v[1]) ms = 0;
            else if (el[1] && g[0] && ms < SMAX) ms++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
